// File: rtl/cac_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : cac_uart_transmitter
// Brief    : CAC UART transmit path: byte FIFO feeding an 8N1, MSB-first serialiser.
// Revision : 1.0
// ============================================================================
module cac_uart_transmitter #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUDRATE        = 115_200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          cac_uart_tx
);

  localparam int c_bit_cycles = CLOCK_FREQUENCY / BAUDRATE;
  localparam int c_baud_w     = (c_bit_cycles > 1) ? $clog2(c_bit_cycles) : 1;
  localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_bit_cycles - 1);
  localparam logic [c_ptr_w:0]    c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_baud_w-1:0]  r_baud_cnt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_next;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_bit_end;
  logic                 w_fifo_nonempty;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;

  assign tx_ready        = (r_count != c_fifo_full);
  assign fifo_count      = r_count;
  assign busy            = (r_state != ST_IDLE);
  assign cac_uart_tx     = r_tx;
  assign w_wr            = tx_valid && tx_ready;
  assign w_fifo_nonempty = (r_count != '0);
  assign w_bit_end       = (r_baud_cnt == c_baud_last);

  // Next-state logic also computes the next line level so the pin stays registered.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    w_tx_next      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = 3'd7;
          w_tx_next      = r_shift[7];
        end
      end
      ST_DATA: begin
        w_tx_next = r_shift[r_bit_idx];
        if (w_bit_end) begin
          if (r_bit_idx == 3'd0) begin
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx - 3'd1;
            w_tx_next      = r_shift[w_bit_idx_next];
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (w_fifo_nonempty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd7;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      // Every state entry coincides with a bit end (or leaving IDLE), so this reloads on entry.
      if (r_state == ST_IDLE || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + c_baud_w'(1);
      end
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cac_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cac_uart_transmitter
// Brief    : Scoreboard bench; a line decoder pops expected bytes per frame.
// Revision : 1.0
// ============================================================================
module tb_cac_uart_transmitter;

  localparam int CLK_F = 100;
  localparam int BAUD  = 6;
  localparam int B     = 16;   // 100/6 truncated
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [4:0] fifo_count;
  logic       busy;
  logic       cac_uart_tx;

  cac_uart_transmitter #(
    .CLOCK_FREQUENCY(CLK_F),
    .BAUDRATE       (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .cac_uart_tx(cac_uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];
  int         starts[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_frames = 0;
  bit         mon_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [7:0] d, input bit accept);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    if (accept) sb.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_active) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", (n < budget), 1);
    tick();
    check("idle_busy", busy, 0);
    check("idle_line", cac_uart_tx, 1);
  endtask

  // Line decoder: one start, 8 data (MSB first), one stop, each exactly B cycles.
  initial begin
    logic       cur;
    bit         jit;
    int         c;
    int         b;
    logic [9:0] bits;
    logic [7:0] d;
    logic [7:0] e;
    cur = 1'b1; jit = 1'b0; c = 0; b = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (cac_uart_tx === 1'b0) begin
          mon_active = 1'b1;
          starts.push_back(cyc);
          cur = 1'b0; c = 1; b = 0; jit = 1'b0;
        end
      end else begin
        if (c == 0) cur = cac_uart_tx;
        else if (cac_uart_tx !== cur) jit = 1'b1;
        c++;
      end
      if (mon_active && c == B) begin
        bits[b] = cur;
        b++;
        c = 0;
        if (b == 10) begin
          mon_active = 1'b0;
          d = {bits[1], bits[2], bits[3], bits[4], bits[5], bits[6], bits[7], bits[8]};
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          check("bit_stable", jit, 0);
          check("frame_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame_data", d, e);
          end
          n_frames++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int peak;
    int f0;
    logic [7:0] burst [5];
    logic [7:0] loop  [4];
    burst = '{8'h10, 8'h01, 8'h11, 8'h11, 8'h30};
    loop  = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

    rst = 1'b0;
    ticks(3);
    check("rst_line", cac_uart_tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    rst = 1'b1;
    tick();

    // Single byte with latency and busy-length checks
    write(8'h10, 1'b1);
    check("lat_count1", fifo_count, 1);
    check("lat_busy0", busy, 0);
    check("lat_line_idle", cac_uart_tx, 1);
    tick();
    check("lat_busy1", busy, 1);
    check("lat_line_start", cac_uart_tx, 0);
    check("lat_count0", fifo_count, 0);
    n = 0;
    while (busy && n < 20 * B) begin
      n++;
      tick();
    end
    check("busy_len", n, 10 * B);
    wait_drain(4 * B);

    // Burst: back-to-back frames, peak occupancy 4
    starts.delete();
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      write(burst[i], 1'b1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    wait_drain(60 * B);
    check("burst_peak", peak, 4);
    check("burst_frames", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++) check("burst_gap", starts[i] - starts[i-1], 10 * B);
    if (starts.size() == 5) check("burst_span", starts[4] - starts[0] + 10 * B, 50 * B);

    // Loopback pattern set
    for (int i = 0; i < 4; i++) write(loop[i], 1'b1);
    wait_drain(50 * B);

    // FIFO full: 17 accepted, 18th and the write on the next pop edge rejected
    starts.delete();
    for (int i = 0; i < 18; i++) write(8'h40 + 8'(i), (i < 17));
    check("full_count", fifo_count, 16);
    check("full_ready", tx_ready, 0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    ticks(10 * B - 17);
    check("prepop_count", fifo_count, 16);
    check("prepop_ready", tx_ready, 0);
    tick();
    tx_valid = 1'b0;
    check("pop_edge_reject", fifo_count, 15);
    check("pop_edge_ready", tx_ready, 1);
    wait_drain(200 * B);
    check("full_frames", starts.size(), 17);

    // Reset during DATA bit 4 of 0xA5 with 0x77 queued
    write(8'hA5, 1'b1);
    write(8'h77, 1'b1);
    ticks(4 * B + B / 2);
    check("bit4_level", cac_uart_tx, 0);
    check("mid_count", fifo_count, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_line", cac_uart_tx, 1);
    check("async_busy", busy, 0);
    check("async_count", fifo_count, 0);
    sb.delete();
    ticks(2);
    rst = 1'b1;
    tick();
    f0 = n_frames;
    write(8'h3C, 1'b1);
    wait_drain(20 * B);
    ticks(12 * B);
    check("post_rst_frames", n_frames - f0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
